phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of flip-flop stages synchronizing exec (legal values 2..4).
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 exec  input  1  active-high run/stop request level (debounced button, asynchronous to clock).
REQ-005 halt  input  1  active-high synchronous stop request from the datapath (HLT decoded).
REQ-006 phase  output  3  current phase index, 0..4.
REQ-007 running  output  1  high while the sequencer advances phases.
REQ-008 register_reset  output  1  active-high clear for the processor register file and PC.
REQ-009 p1, p2, p3, p4, p5  output  1 each  phase strobes.

Function
REQ-010 exec SHALL pass through SYNC_STAGES flip-flops, then a rising-edge detector; one detected edge SHALL produce exactly one exec_pulse, one clock long.
REQ-011 Holding exec high SHALL produce no further pulses; another pulse SHALL need exec low for at least one synchronized sample.
REQ-012 With SYNC_STAGES=2, running SHALL change on the 3rd rising clock edge at which exec is sampled high.
REQ-013 Halted (running=0): exec_pulse SHALL set running=1, and phase SHALL stay 0.
REQ-014 Running: phase SHALL advance 0,1,2,3,4,0,... one step per clock, wrapping from 4 to 0.
REQ-015 Running, exec_pulse: a stop request SHALL be latched; it SHALL clear running on the edge where phase wraps 4->0, so the current instruction completes.
REQ-016 Running, halt=1 sampled while phase=4: running SHALL clear on the same 4->0 wrap edge.
REQ-017 halt sampled in phases 0..3 SHALL be ignored.
REQ-018 exec_pulse and halt in the same cycle SHALL act as a single stop; no restart.
REQ-019 A stopped sequencer SHALL always rest at phase=0.
REQ-020 A latched stop request SHALL clear when running clears.
REQ-021 p(k) SHALL be 1 if and only if running=1 and phase=k-1.
REQ-022 p1..p5 SHALL be one-hot while running and all 0 while stopped.
REQ-023 phase, running and register_reset SHALL be registered outputs; p1..p5 SHALL be combinational decodes of those registers only.
REQ-024 Phase values 5..7 SHALL never occur; if reached they SHALL return to 0 on the next edge.

Reset
REQ-025 reset=1 SHALL immediately force phase=0, running=0, stop request=0, synchronizer and edge registers=0, p1..p5=0 and register_reset=1, independent of clock.
REQ-026 register_reset SHALL stay 1 while reset is high and through the first rising clock edge after reset falls, then go 0.
REQ-027 An exec_pulse SHALL NOT be accepted on the clock edge where register_reset clears.
REQ-028 reset mid-run (any phase) SHALL abort the instruction with the REQ-025 values; no pending stop or run state SHALL survive.

Verification
REQ-029 Pulse reset, then hold exec=0 for 10 clocks -> register_reset 1 then 0 after one edge; phase=0, running=0, p1..p5=0 throughout.
REQ-030 exec 0->1 and held -> running=1 on the 3rd edge; phase 0,1,2,3,4,0,1 with p1,p2,p3,p4,p5,p1,p2 one-hot; no second start.
REQ-031 Second exec press while phase=2 -> phases 3,4 complete, then phase=0, running=0, all p=0.
REQ-032 halt=1 only at phase 1, then only at phase 4 -> phase-1 halt ignored; stop at the following 4->0 wrap.
REQ-033 Assert reset asynchronously (between edges) at phase 3 -> outputs take reset values immediately; after release, an exec press is required to restart.
REQ-034 exec_pulse coinciding with halt at phase 4 -> single stop at phase 0, running stays 0 next cycle.

Source files
------------

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: synchronizes a run/stop button, then steps
// phases 0..4 while running, stopping only at the 4->0 instruction boundary.
module phase_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       exec,
    input  logic       halt,
    output logic [2:0] phase,
    output logic       running,
    output logic       register_reset,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic       p4,
    output logic       p5
);

    typedef enum logic {
        ST_HALTED  = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

    localparam logic [2:0] LAST_PHASE = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   exec_prev;
    logic                   exec_pulse;
    logic                   pulse_ok;

    run_state_t state, state_next;
    logic [2:0] phase_next;
    logic       stop_req, stop_req_next;
    logic       at_boundary;

    // Synchronizer chain and edge detector; exec is asynchronous to clock.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, exactly like hardware.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            exec_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], exec};
            exec_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign exec_pulse = sync_q[SYNC_STAGES-1] & ~exec_prev;
    // A press is never accepted on the edge that releases the register clear.
    assign pulse_ok   = exec_pulse & ~register_reset;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_HALTED;
            phase          <= 3'd0;
            stop_req       <= 1'b0;
            register_reset <= 1'b1;
        end else begin
            state          <= state_next;
            phase          <= phase_next;
            stop_req       <= stop_req_next;
            register_reset <= 1'b0;
        end
    end

    // Illegal phases 5..7 are treated as the boundary so they fall back to 0.
    assign at_boundary = (phase >= LAST_PHASE);

    // Next-state logic.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next    = state;
        phase_next    = 3'd0;
        stop_req_next = 1'b0;
        unique case (state)
            ST_HALTED: begin
                if (pulse_ok) state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                stop_req_next = stop_req | pulse_ok;
                if (at_boundary) begin
                    phase_next = 3'd0;
                    // halt only counts in the last phase; a stop lands on the wrap.
                    if (stop_req | pulse_ok | halt) begin
                        state_next    = ST_HALTED;
                        stop_req_next = 1'b0;
                    end
                end else begin
                    phase_next = phase + 3'd1;
                end
            end
            default: state_next = ST_HALTED;
        endcase
    end

    // Output decode of registered state only.
    always_comb begin
        running = (state == ST_RUNNING);
        p1 = running && (phase == 3'd0);
        p2 = running && (phase == 3'd1);
        p3 = running && (phase == 3'd2);
        p4 = running && (phase == 3'd3);
        p5 = running && (phase == 3'd4);
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random
// exec/halt/reset traffic compared against a cycle-level behavioural model.
module tb_phase_sequencer;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       exec  = 1'b0;
    logic       halt  = 1'b0;
    logic [2:0] phase;
    logic       running;
    logic       register_reset;
    logic       p1, p2, p3, p4, p5;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          m_phase;
    bit          m_run;
    bit          m_stop;
    bit          m_rr;
    bit [SYNC:0] m_hist;   // m_hist[0] is the most recent exec sample

    phase_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .clock          (clock),
        .reset          (reset),
        .exec           (exec),
        .halt           (halt),
        .phase          (phase),
        .running        (running),
        .register_reset (register_reset),
        .p1             (p1),
        .p2             (p2),
        .p3             (p3),
        .p4             (p4),
        .p5             (p5)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_run   = 1'b0;
        m_stop  = 1'b0;
        m_rr    = 1'b1;
        m_hist  = '0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_step();
        bit pulse;
        if (reset) begin
            model_reset();
            return;
        end
        // A rising edge is seen SYNC samples after exec first reads high.
        pulse = m_hist[SYNC-1] && !m_hist[SYNC] && !m_rr;
        if (!m_run) begin
            if (pulse) m_run = 1'b1;
        end else begin
            if (pulse) m_stop = 1'b1;
            if (m_phase == 4) begin
                if (m_stop || halt) begin
                    m_run  = 1'b0;
                    m_stop = 1'b0;
                end
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        m_rr   = 1'b0;
        m_hist = {m_hist[SYNC-1:0], exec};
    endtask

    task automatic compare_all(input string tag);
        logic [4:0] exp_p;
        exp_p = '0;
        if (m_run) exp_p[m_phase] = 1'b1;
        check({tag, ".phase"},   8'(phase),          8'(m_phase));
        check({tag, ".running"}, 8'(running),        8'(m_run));
        check({tag, ".rr"},      8'(register_reset), 8'(m_rr));
        check({tag, ".p"},       8'({p5, p4, p3, p2, p1}), 8'(exp_p));
    endtask

    // Drive inputs at the falling edge, step the model on the rising edge,
    // and compare at the next falling edge.
    task automatic tick(input logic e, input logic h, input string tag);
        exec = e;
        halt = h;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all({tag, ".async"});
        @(negedge clock);
        @(negedge clock);
        compare_all({tag, ".held"});
        reset = 1'b0;
    endtask

    task automatic wait_phase(input int target, input logic e, input string tag);
        int n;
        n = 0;
        while (!(m_run && m_phase == target) && n < 20) begin
            tick(e, 1'b0, tag);
            n++;
        end
        check({tag, ".reached"}, 8'(m_run && m_phase == target), 8'd1);
    endtask

    task automatic press(input string tag);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, tag);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        #1;
        compare_all("por");
        @(negedge clock);
        reset = 1'b0;

        // Reset release with exec idle.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "idle");

        // Press and hold: start on the third edge, one start only.
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, "start_hold");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "release");

        // Second press around phase 2: finish the instruction, then stop.
        wait_phase(0, 1'b0, "sync0");
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, "stop_press");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "stopped");
        check("stop.running", 8'(running), 8'd0);

        // halt in phase 1 ignored, halt in phase 4 stops at the wrap.
        press("restart");
        wait_phase(1, 1'b0, "to_p1");
        tick(1'b0, 1'b1, "halt_p1");
        wait_phase(4, 1'b0, "to_p4");
        tick(1'b0, 1'b1, "halt_p4");
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "after_halt");

        // Asynchronous reset in phase 3; stays stopped until a new press.
        press("restart2");
        wait_phase(3, 1'b0, "to_p3");
        async_reset("mid_run");
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, "post_rst");
        press("restart3");

        // exec pulse coinciding with halt in phase 4.
        wait_phase(4 - SYNC, 1'b0, "align");
        for (int i = 0; i < SYNC; i++) tick(1'b1, 1'b0, "coincide_lead");
        tick(1'b1, 1'b1, "coincide");
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, "coincide_after");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "coincide_rel");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic e_next;
            e_next = ($urandom_range(0, 5) == 0) ? ~exec : exec;
            if ($urandom_range(0, 119) == 0) begin
                async_reset("rnd");
            end else begin
                tick(e_next, logic'($urandom_range(0, 2) == 0), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
